// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory macro between the instruction-fetch
// port (F) and the load/store data port (D). One transaction in flight at a
// time; every output is registered.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W        = 7,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned MEM_LATENCY   = 1,  // 1..4
    parameter int unsigned DATA_PRIORITY = 0   // 0: round-robin, 1: D wins ties
) (
    input  logic              clk,
    input  logic              reset,
    // fetch port
    input  logic              f_req,
    input  logic              f_we,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic [DATA_W-1:0] f_wdata,
    output logic              f_gnt,
    output logic              f_rvalid,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    // shared read data
    output logic [DATA_W-1:0] rdata,
    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              busy,
    output logic [7:0]        f_stall,
    output logic [7:0]        d_stall
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e              state_q;
    logic                owner_q;       // port of the current transaction: 0 = F, 1 = D
    logic                last_owner_q;  // port of the last issued transaction
    logic [2:0]          lat_q;
    logic                f_gnt_q, d_gnt_q, f_rvalid_q, d_rvalid_q;
    logic                mem_en_q, mem_we_q, busy_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q, rdata_q;
    logic [7:0]          f_stall_q, d_stall_q;
    logic                pick_d;

    // Arbitration: a lone requester wins; on a tie apply the priority policy.
    always_comb begin
        pick_d = 1'b0;
        if (f_req && d_req) begin
            pick_d = (DATA_PRIORITY != 0) ? 1'b1 : !last_owner_q;
        end else begin
            pick_d = d_req;
        end
    end

    // Transaction FSM, registered outputs and saturating stall counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= 1'b1;
            last_owner_q <= 1'b1;  // D, so F wins the first tie
            lat_q        <= '0;
            f_gnt_q      <= 1'b0;
            d_gnt_q      <= 1'b0;
            f_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            f_stall_q    <= '0;
            d_stall_q    <= '0;
        end else begin
            f_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            mem_en_q   <= 1'b0;

            if (f_req && !f_gnt_q && (f_stall_q != 8'hFF)) f_stall_q <= f_stall_q + 8'd1;
            if (d_req && !d_gnt_q && (d_stall_q != 8'hFF)) d_stall_q <= d_stall_q + 8'd1;

            unique case (state_q)
                StIdle: begin
                    if (f_req || d_req) begin
                        owner_q     <= pick_d;
                        mem_we_q    <= pick_d ? d_we    : f_we;
                        mem_addr_q  <= pick_d ? d_addr  : f_addr;
                        mem_wdata_q <= pick_d ? d_wdata : f_wdata;
                        mem_en_q    <= 1'b1;
                        f_gnt_q     <= !pick_d;
                        d_gnt_q     <= pick_d;
                        busy_q      <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    last_owner_q <= owner_q;
                    if (mem_we_q) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        lat_q   <= 3'(MEM_LATENCY);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (lat_q == 3'd1) begin
                        rdata_q    <= mem_rdata;
                        f_rvalid_q <= !owner_q;
                        d_rvalid_q <= owner_q;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end else begin
                        lat_q <= lat_q - 3'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign f_gnt     = f_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign f_rvalid  = f_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign f_stall   = f_stall_q;
    assign d_stall   = d_stall_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single 128x8 memory between the instruction-fetch requester (port F) and the LD/ST data requester (port D).
- Runs one memory transaction at a time and sequences issue, latency wait and read-data return.
- Keeps per-port stall counters for the efficiency monitor, alongside the cycle counter `cc`.
- Sits between the processor core and the memory macro.

Parameters:
- ADDR_W, 7, memory address width.
- DATA_W, 8, data width.
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..4.
- DATA_PRIORITY, 0, 0 = round-robin between F and D; 1 = D always wins a tie.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- f_req  in  1  fetch request; held until f_gnt
- f_we  in  1  fetch write enable; the core drives 0, the arbiter honours it
- f_addr  in  ADDR_W  fetch address
- f_wdata  in  DATA_W  fetch write data
- f_gnt  out  1  one-cycle pulse: F transaction issued
- f_rvalid  out  1  one-cycle pulse: rdata belongs to F
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse: D transaction issued
- d_rvalid  out  1  one-cycle pulse: rdata belongs to D
- rdata  out  DATA_W  captured read data, shared by both ports
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high whenever the FSM is not IDLE
- f_stall  out  8  saturating count of F stall cycles
- d_stall  out  8  saturating count of D stall cycles

Behaviour:
- All outputs are registered. Reset values:
  - mem_en, mem_we, gnts, rvalids, busy = 0.
  - mem_addr, mem_wdata, rdata = 0; stall counters = 0.
  - FSM = IDLE; last_owner = D, so F wins the first tie.
- FSM states are IDLE, ISSUE and WAIT.
- IDLE: requests are sampled only in this state.
  - With no request, the FSM stays in IDLE.
  - Otherwise it selects an owner and latches the owner's we/addr/wdata into the mem_* registers, then moves to ISSUE.
- Tie (both ports requesting):
  - DATA_PRIORITY=0: the port that is not last_owner wins.
  - DATA_PRIORITY=1: D wins.
- ISSUE lasts exactly 1 cycle: mem_en=1 and the owner's gnt=1. last_owner is updated.
  - Write: next state is IDLE.
  - Read: next state is WAIT, with the latency counter loaded to MEM_LATENCY.
- WAIT: the counter decrements each cycle.
  - In the cycle the counter reaches its last value (MEM_LATENCY cycles after the ISSUE cycle), mem_rdata is captured into rdata.
  - Next state is IDLE. In that IDLE cycle the owner's rvalid=1 for 1 cycle.
  - An arbitration in that same cycle is allowed: back-to-back operation.
- Timing with MEM_LATENCY=1 and the request seen in cycle 0:
  - Write: ISSUE/gnt in cycle 1; next request sampled in cycle 2. One write every 2 cycles.
  - Read: ISSUE/gnt in cycle 1, capture in cycle 2, rvalid in cycle 3. One read every 3 cycles.
- Requester rule: req, we, addr and wdata stay stable until gnt is seen; req deasserts the cycle after gnt unless a new request follows. Fields are sampled only in IDLE, so changes outside IDLE are ignored.
- mem_en, mem_we, mem_addr and mem_wdata are valid only in ISSUE. mem_en=0 in all other states; the other mem_* outputs hold their values.
- rdata holds its value until the next read capture.
- Stall counters: a port's counter increments every cycle its req=1 and its gnt=0, and saturates at 255. It is cleared only by reset. A port waiting during another port's transaction also counts as stalled.
- Reset mid-operation: the FSM returns to IDLE next cycle with mem_en=0. Any in-flight read is discarded and no rvalid is produced. Counters clear and last_owner returns to D.
- The requester is responsible for keeping addresses within 0..127 (ADDR_W); the arbiter does not check them.

Test Plan:
- Single read: F reads addr 0x05, memory holds 0x3C, latency 1. Required: f_gnt and mem_en in cycle 1; f_rvalid with rdata=0x3C in cycle 3; d_rvalid stays 0; f_stall=1.
- Tie, round-robin: both req continuously after reset, reads. Grant order F,D,F,D. Each rvalid goes only to its owner, 3 cycles apart.
- Write then read: D stores 0xA7 to 0x7F, then D loads 0x7F. Required: mem_we=1 only in the write ISSUE; load returns 0xA7; the second d_gnt comes 2 cycles after the first.
- DATA_PRIORITY=1 with both ports requesting continuously: D granted every arbitration, F never granted; f_stall counts up and saturates at 255, does not wrap.
- MEM_LATENCY=3: a read gives rvalid 4 cycles after gnt; busy is high for 4 cycles.
- Reset asserted in the WAIT cycle of an F read: no f_rvalid; the next cycle shows busy=0 and stall counters=0; a fresh request completes normally.
